// File: rtl/control_unit.sv
// Multi-cycle instruction control unit: decodes opcodes into datapath strobes and sequences MLT, STIN and LOUT.
// Optional multiply sequencing is enabled by defining CONTROL_UNIT_MLT_EN; without it MLT/MLTI retire as illegal.
// Opcodes: ADD=0 SUB=1 ADDI=2 SUBI=3 MLT=4 MLTI=5 JMP=6 BEQ=7 STIN=8 LOUT=9 NOP=10. ALU: RADD=1 RSUB=2 RMLT=3.
module control_unit #(
    parameter int OPCODE_W   = 6,
    parameter int ALU_W      = 3,
    parameter int MLT_CYCLES = 3
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                instr_valid,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                ZF,
    input  logic                in_valid,
    input  logic                out_ready,
    output logic                instr_ready,
    output logic [ALU_W-1:0]    alu_func,
    output logic                reg_write,
    output logic                immediate,
    output logic                pc_rel_branch,
    output logic                read_in,
    output logic                write_out,
    output logic                pc_en,
    output logic                illegal_op
);

    localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_STIN = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_LOUT = OPCODE_W'(9);
    localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(10);

    localparam logic [ALU_W-1:0] RADD = ALU_W'(1);
    localparam logic [ALU_W-1:0] RSUB = ALU_W'(2);

    localparam logic [1:0] READY    = 2'd0;
    localparam logic [1:0] IN_WAIT  = 2'd1;
    localparam logic [1:0] OUT_WAIT = 2'd2;

`ifdef CONTROL_UNIT_MLT_EN
    localparam logic [OPCODE_W-1:0] OP_MLT  = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_MLTI = OPCODE_W'(5);
    localparam logic [ALU_W-1:0]    RMLT    = ALU_W'(3);
    localparam logic [1:0]          MLT_BUSY = 2'd3;
    localparam int                  CNT_W    = 4;
    localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(MLT_CYCLES - 1);
`endif

    logic [1:0]       r_state;
    logic [ALU_W-1:0] r_alu_func;
    logic             r_reg_write;
    logic             r_immediate;
    logic             r_pc_rel_branch;
    logic             r_pc_en;
    logic             r_illegal_op;

    logic [ALU_W-1:0] w_dec_alu;
    logic             w_dec_reg_write;
    logic             w_dec_immediate;
    logic             w_dec_branch;
    logic             w_dec_illegal;
    logic             w_dec_pc_en;
    logic [1:0]       w_dec_state;

    logic w_accept;
    logic w_done;
    logic w_mlt_busy;
    logic w_mlt_last;

    // Single-cycle ops produce registered strobes for E1; multi-cycle ops only pick the wait state.
    always_comb begin
        w_dec_alu       = '0;
        w_dec_reg_write = 1'b0;
        w_dec_immediate = 1'b0;
        w_dec_branch    = 1'b0;
        w_dec_illegal   = 1'b0;
        w_dec_pc_en     = 1'b1;
        w_dec_state     = READY;
        case (opcode)
            OP_ADD:  begin w_dec_alu = RADD; w_dec_reg_write = 1'b1; end
            OP_ADDI: begin w_dec_alu = RADD; w_dec_reg_write = 1'b1; w_dec_immediate = 1'b1; end
            OP_SUB:  begin w_dec_alu = RSUB; w_dec_reg_write = 1'b1; end
            OP_SUBI: begin w_dec_alu = RSUB; w_dec_reg_write = 1'b1; w_dec_immediate = 1'b1; end
            OP_JMP:  w_dec_branch = 1'b1;
            OP_BEQ:  w_dec_branch = ZF;
            OP_NOP:  w_dec_pc_en  = 1'b1;
            OP_STIN: begin w_dec_pc_en = 1'b0; w_dec_state = IN_WAIT; end
            OP_LOUT: begin w_dec_pc_en = 1'b0; w_dec_state = OUT_WAIT; end
`ifdef CONTROL_UNIT_MLT_EN
            OP_MLT, OP_MLTI: begin w_dec_pc_en = 1'b0; w_dec_state = MLT_BUSY; end
`endif
            default: w_dec_illegal = 1'b1;
        endcase
    end

    assign w_done = ((r_state == IN_WAIT) && in_valid) ||
                    ((r_state == OUT_WAIT) && out_ready) || w_mlt_last;
    assign instr_ready = n_reset && ((r_state == READY) || w_done);
    assign w_accept    = instr_valid && instr_ready;

    // A new opcode accepted in a completion cycle overrides the return to READY.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state         <= READY;
            r_alu_func      <= '0;
            r_reg_write     <= 1'b0;
            r_immediate     <= 1'b0;
            r_pc_rel_branch <= 1'b0;
            r_pc_en         <= 1'b0;
            r_illegal_op    <= 1'b0;
        end else begin
            r_alu_func      <= '0;
            r_reg_write     <= 1'b0;
            r_immediate     <= 1'b0;
            r_pc_rel_branch <= 1'b0;
            r_pc_en         <= 1'b0;
            r_illegal_op    <= 1'b0;
            if (w_accept) begin
                r_state         <= w_dec_state;
                r_alu_func      <= w_dec_alu;
                r_reg_write     <= w_dec_reg_write;
                r_immediate     <= w_dec_immediate;
                r_pc_rel_branch <= w_dec_branch;
                r_pc_en         <= w_dec_pc_en;
                r_illegal_op    <= w_dec_illegal;
            end else if (w_done) begin
                r_state <= READY;
            end
        end
    end

`ifdef CONTROL_UNIT_MLT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_mlt_imm;

    // Counter runs down to zero; the zero cycle is the retiring cycle of the multiply.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_cnt     <= '0;
            r_mlt_imm <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= CNT_LOAD;
            r_mlt_imm <= (opcode == OP_MLTI);
        end else if (w_mlt_busy && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign w_mlt_busy = (r_state == MLT_BUSY);
    assign w_mlt_last = w_mlt_busy && (r_cnt == '0);
    assign alu_func   = w_mlt_busy ? RMLT : r_alu_func;
    assign immediate  = r_immediate || (w_mlt_busy && r_mlt_imm);
`else
    logic [4:0] w_unused_mlt_cycles;
    assign w_unused_mlt_cycles = 5'(MLT_CYCLES);
    assign w_mlt_busy = 1'b0;
    assign w_mlt_last = 1'b0;
    assign alu_func   = r_alu_func;
    assign immediate  = r_immediate;
`endif

    assign reg_write     = r_reg_write || ((r_state == IN_WAIT) && in_valid) || w_mlt_last;
    assign pc_en         = r_pc_en || w_done;
    assign read_in       = (r_state == IN_WAIT);
    assign write_out     = (r_state == OUT_WAIT);
    assign pc_rel_branch = r_pc_rel_branch;
    assign illegal_op    = r_illegal_op;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: table-driven single-cycle ops plus hand sequences for waits and reset.
// Multiply sequences run only when CONTROL_UNIT_MLT_EN is defined; otherwise MLT/MLTI are checked as illegal.
module tb_control_unit;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_ADDI = 6'd2;
    localparam logic [5:0] OP_SUBI = 6'd3;
    localparam logic [5:0] OP_MLT  = 6'd4;
    localparam logic [5:0] OP_MLTI = 6'd5;
    localparam logic [5:0] OP_JMP  = 6'd6;
    localparam logic [5:0] OP_BEQ  = 6'd7;
    localparam logic [5:0] OP_STIN = 6'd8;
    localparam logic [5:0] OP_LOUT = 6'd9;
    localparam logic [5:0] OP_NOP  = 6'd10;

    localparam logic [2:0] RADD = 3'd1;
    localparam logic [2:0] RSUB = 3'd2;
    localparam logic [2:0] RMLT = 3'd3;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       instr_valid;
    logic [5:0] opcode;
    logic       ZF;
    logic       in_valid;
    logic       out_ready;
    logic       instr_ready;
    logic [2:0] alu_func;
    logic       reg_write;
    logic       immediate;
    logic       pc_rel_branch;
    logic       read_in;
    logic       write_out;
    logic       pc_en;
    logic       illegal_op;

    always #5 clk = ~clk;

    control_unit #(.OPCODE_W(6), .ALU_W(3), .MLT_CYCLES(3)) dut (
        .clk(clk), .n_reset(n_reset), .instr_valid(instr_valid), .opcode(opcode),
        .ZF(ZF), .in_valid(in_valid), .out_ready(out_ready), .instr_ready(instr_ready),
        .alu_func(alu_func), .reg_write(reg_write), .immediate(immediate),
        .pc_rel_branch(pc_rel_branch), .read_in(read_in), .write_out(write_out),
        .pc_en(pc_en), .illegal_op(illegal_op)
    );

    // Output vector layout: {ready, alu[2:0], reg_write, immediate, branch, read_in, write_out, pc_en, illegal}
    typedef logic [10:0] outv_t;
    typedef struct { string name; outv_t exp; } sb_t;
    typedef struct { string name; logic [5:0] op; logic zf; outv_t exp; } vec_t;

    sb_t  sbQ[$];
    vec_t vecs[$];
    int   testsRun = 0;
    int   testsFailed = 0;

    function automatic outv_t mk(input logic rdy, input logic [2:0] alu, input logic rw,
                                 input logic imm, input logic br, input logic rd,
                                 input logic wr, input logic pc, input logic ill);
        return {rdy, alu, rw, imm, br, rd, wr, pc, ill};
    endfunction

    localparam outv_t IDLE = 11'b1_000_0000000;
    localparam outv_t ZERO = 11'b0;

    task automatic applyStimulus(input logic v, input logic [5:0] op, input logic zf,
                                 input logic iv, input logic ordy);
        instr_valid = v;
        opcode      = op;
        ZF          = zf;
        in_valid    = iv;
        out_ready   = ordy;
    endtask

    // Pops the oldest expectation and compares it against mid-cycle DUT outputs.
    task automatic checkOutput();
        outv_t act;
        sb_t   e;
        @(negedge clk);
        act = {instr_ready, alu_func, reg_write, immediate, pc_rel_branch,
               read_in, write_out, pc_en, illegal_op};
        testsRun++;
        if (sbQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_empty: got %b, nothing expected", act);
        end else begin
            e = sbQ.pop_front();
            if (act !== e.exp) begin
                testsFailed++;
                $display("[TB] FAIL %s: got %b required %b (rdy,alu,rw,imm,br,rd,wr,pc,ill)",
                         e.name, act, e.exp);
            end
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string nm, input logic v, input logic [5:0] op, input logic zf,
                       input logic iv, input logic ordy, input outv_t e);
        applyStimulus(v, op, zf, iv, ordy);
        sbQ.push_back('{nm, e});
        checkOutput();
        nextCycle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs.push_back('{"add",      OP_ADD,  1'b0, mk(1, RADD, 1, 0, 0, 0, 0, 1, 0)});
        vecs.push_back('{"addi",     OP_ADDI, 1'b0, mk(1, RADD, 1, 1, 0, 0, 0, 1, 0)});
        vecs.push_back('{"sub",      OP_SUB,  1'b1, mk(1, RSUB, 1, 0, 0, 0, 0, 1, 0)});
        vecs.push_back('{"subi",     OP_SUBI, 1'b0, mk(1, RSUB, 1, 1, 0, 0, 0, 1, 0)});
        vecs.push_back('{"beq_zf0",  OP_BEQ,  1'b0, mk(1, 3'd0, 0, 0, 0, 0, 0, 1, 0)});
        vecs.push_back('{"beq_zf1",  OP_BEQ,  1'b1, mk(1, 3'd0, 0, 0, 1, 0, 0, 1, 0)});
        vecs.push_back('{"jmp",      OP_JMP,  1'b0, mk(1, 3'd0, 0, 0, 1, 0, 0, 1, 0)});
        vecs.push_back('{"nop",      OP_NOP,  1'b1, mk(1, 3'd0, 0, 0, 0, 0, 0, 1, 0)});
        vecs.push_back('{"ill_3f",   6'h3F,   1'b1, mk(1, 3'd0, 0, 0, 0, 0, 0, 1, 1)});
        vecs.push_back('{"ill_0b",   6'h0B,   1'b0, mk(1, 3'd0, 0, 0, 0, 0, 0, 1, 1)});
`ifndef CONTROL_UNIT_MLT_EN
        vecs.push_back('{"mlt_ill",  OP_MLT,  1'b0, mk(1, 3'd0, 0, 0, 0, 0, 0, 1, 1)});
        vecs.push_back('{"mlti_ill", OP_MLTI, 1'b0, mk(1, 3'd0, 0, 0, 0, 0, 0, 1, 1)});
`endif

        // Reset holds every output low, even with traffic on the inputs.
        n_reset = 1'b0;
        cyc("reset_outputs", 1'b1, OP_ADD, 1'b1, 1'b1, 1'b1, ZERO);
        cyc("reset_hold",    1'b1, OP_STIN, 1'b0, 1'b0, 1'b0, ZERO);
        n_reset = 1'b1;
        cyc("ready_after_reset", 1'b0, OP_NOP, 1'b0, 1'b0, 1'b0, IDLE);

        // Back-to-back issue: each expectation is pushed when driven and popped a cycle later.
        sbQ.push_back('{"idle_before_table", IDLE});
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(1'b1, vecs[i].op, vecs[i].zf, 1'b0, 1'b0);
            checkOutput();
            sbQ.push_back('{vecs[i].name, vecs[i].exp});
            nextCycle();
        end
        applyStimulus(1'b0, OP_NOP, 1'b0, 1'b0, 1'b0);
        checkOutput();
        nextCycle();
        cyc("idle_after_table", 1'b0, OP_NOP, 1'b0, 1'b0, 1'b0, IDLE);

        // STIN completing in E4; an opcode offered while waiting must be ignored.
        cyc("stin_accept",  1'b1, OP_STIN, 1'b0, 1'b0, 1'b0, IDLE);
        cyc("stin_e1",      1'b0, OP_NOP,  1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        cyc("stin_e2_busy", 1'b1, OP_ADD,  1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        cyc("stin_e3",      1'b0, OP_NOP,  1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        cyc("stin_e4_done", 1'b0, OP_NOP,  1'b0, 1'b1, 1'b0, mk(1, 0, 1, 0, 0, 1, 0, 1, 0));
        cyc("stin_after",   1'b0, OP_NOP,  1'b0, 1'b0, 1'b0, IDLE);

        // LOUT finishing in E1 while the next opcode is taken in the same cycle.
        cyc("lout_accept",    1'b1, OP_LOUT, 1'b0, 1'b0, 1'b0, IDLE);
        cyc("lout_e1_done",   1'b1, OP_ADD,  1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0, 0, 0, 1, 1, 0));
        cyc("add_after_lout", 1'b0, OP_NOP,  1'b0, 1'b0, 1'b0, mk(1, RADD, 1, 0, 0, 0, 0, 1, 0));

        cyc("lout2_accept",  1'b1, OP_LOUT, 1'b0, 1'b0, 1'b0, IDLE);
        cyc("lout2_e1_wait", 1'b0, OP_NOP,  1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
        cyc("lout2_e2_done", 1'b0, OP_NOP,  1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0, 0, 0, 1, 1, 0));
        cyc("lout2_after",   1'b0, OP_NOP,  1'b0, 1'b0, 1'b1, IDLE);

        // Reset in the middle of a STIN wait abandons it without a write.
        cyc("stinr_accept", 1'b1, OP_STIN, 1'b0, 1'b0, 1'b0, IDLE);
        cyc("stinr_e1",     1'b0, OP_NOP,  1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        n_reset = 1'b0;
        cyc("stinr_reset",  1'b0, OP_NOP,  1'b0, 1'b1, 1'b0, ZERO);
        n_reset = 1'b1;
        cyc("stinr_release", 1'b0, OP_NOP, 1'b0, 1'b1, 1'b0, IDLE);
        cyc("stinr_after",   1'b0, OP_NOP, 1'b0, 1'b1, 1'b0, IDLE);

`ifdef CONTROL_UNIT_MLT_EN
        cyc("mlti_accept", 1'b1, OP_MLTI, 1'b0, 1'b0, 1'b0, IDLE);
        cyc("mlti_e1",     1'b1, OP_ADD,  1'b0, 1'b0, 1'b0, mk(0, RMLT, 0, 1, 0, 0, 0, 0, 0));
        cyc("mlti_e2",     1'b0, OP_NOP,  1'b0, 1'b0, 1'b0, mk(0, RMLT, 0, 1, 0, 0, 0, 0, 0));
        cyc("mlti_e3",     1'b0, OP_NOP,  1'b0, 1'b0, 1'b0, mk(1, RMLT, 1, 1, 0, 0, 0, 1, 0));
        cyc("mlti_after",  1'b0, OP_NOP,  1'b0, 1'b0, 1'b0, IDLE);

        cyc("mltr_accept", 1'b1, OP_MLT, 1'b0, 1'b0, 1'b0, IDLE);
        cyc("mltr_e1",     1'b0, OP_NOP, 1'b0, 1'b0, 1'b0, mk(0, RMLT, 0, 0, 0, 0, 0, 0, 0));
        n_reset = 1'b0;
        cyc("mltr_reset",  1'b0, OP_NOP, 1'b0, 1'b0, 1'b0, ZERO);
        n_reset = 1'b1;
        cyc("mltr_release", 1'b0, OP_NOP, 1'b0, 1'b0, 1'b0, IDLE);
        cyc("mltr_after",   1'b0, OP_NOP, 1'b0, 1'b0, 1'b0, IDLE);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter OPCODE_W, default 6, SHALL set the opcode width.
REQ-003 Parameter ALU_W, default 3, SHALL set the alu_func width.
REQ-004 Parameter MLT_CYCLES, default 3, legal 1..16, SHALL set the multiply duration in cycles.
REQ-005 Ports SHALL be:
- clk  in  1  rising-edge clock.
- n_reset  in  1  async active-low reset.
- instr_valid  in  1  opcode present.
- opcode  in  OPCODE_W  instruction opcode; encodings per opcodes.sv.
- ZF  in  1  ALU zero flag.
- in_valid  in  1  input port data available.
- out_ready  in  1  output port can accept.
- instr_ready  out  1  block accepts an opcode this cycle.
- alu_func  out  ALU_W  ALU operation; encodings per alucodes.sv.
- reg_write  out  1  register file write strobe.
- immediate  out  1  select immediate operand.
- pc_rel_branch  out  1  take PC-relative branch.
- read_in  out  1  reading input port.
- write_out  out  1  driving output port.
- pc_en  out  1  instruction retires; advance PC.
- illegal_op  out  1  undecodable opcode retired.

Function
REQ-006 An opcode SHALL be accepted at a rising edge where instr_valid=1 and instr_ready=1; the cycle after acceptance is E1.
REQ-007 FSM states SHALL be READY, MLT_BUSY, IN_WAIT and OUT_WAIT; instr_ready=1 SHALL hold in READY.
REQ-008 ADD, SUB, ADDI, SUBI, JMP, BEQ and NOP SHALL retire in E1, with all their outputs registered and asserted for E1 only; the FSM stays in READY, so throughput is 1 instruction per cycle.
REQ-009 ADD/ADDI SHALL drive alu_func=RADD and SUB/SUBI SHALL drive alu_func=RSUB, with reg_write=1; ADDI and SUBI SHALL also drive immediate=1.
REQ-010 JMP SHALL drive pc_rel_branch=1; BEQ SHALL drive pc_rel_branch equal to ZF as sampled at the acceptance edge.
REQ-011 MLT/MLTI SHALL enter MLT_BUSY and drive alu_func=RMLT during E1..E(MLT_CYCLES); MLTI SHALL also drive immediate=1 over the same span.
REQ-012 For MLT/MLTI, reg_write and pc_en SHALL be 1 only in E(MLT_CYCLES), and instr_ready SHALL be 0 in E1..E(MLT_CYCLES-1); the down-counter loads MLT_CYCLES-1; MLT_CYCLES=1 behaves as a single-cycle op.
REQ-013 STIN SHALL enter IN_WAIT and drive read_in=1 and instr_ready=0 from E1 until the first cycle where in_valid=1.
REQ-014 In that STIN completion cycle, reg_write, pc_en and instr_ready SHALL be 1 combinationally, and the FSM SHALL return to READY at the next edge.
REQ-015 LOUT SHALL enter OUT_WAIT and drive write_out=1 and instr_ready=0 from E1 until the first cycle where out_ready=1.
REQ-016 In that LOUT completion cycle, pc_en and instr_ready SHALL be 1, and the FSM SHALL return to READY at the next edge.
REQ-017 If in_valid or out_ready is already 1 in E1, STIN or LOUT SHALL complete in E1 (minimum latency 1).
REQ-018 An unknown opcode SHALL retire as NOP in E1 with illegal_op=1 and pc_en=1.
REQ-019 Outputs not listed for an operation SHALL be 0; pc_en SHALL pulse exactly once per accepted instruction.
REQ-020 In the completion cycle a new opcode MAY be accepted, giving back-to-back issue with no bubble.

Reset
REQ-021 While n_reset=0, the FSM SHALL be READY, the counter 0, and every output 0, including instr_ready.
REQ-022 Reset asserted mid-MLT_BUSY, IN_WAIT or OUT_WAIT SHALL abandon the operation without a reg_write or pc_en pulse.
REQ-023 instr_ready SHALL be 1 in the first cycle after n_reset rises.

Configuration
REQ-024 With macro CONTROL_UNIT_MLT_EN defined, MLT/MLTI SHALL behave per REQ-011 and REQ-012.
REQ-025 With CONTROL_UNIT_MLT_EN undefined, MLT/MLTI SHALL retire as illegal per REQ-018, MLT_BUSY and the counter SHALL be absent, and MLT_CYCLES SHALL be ignored.

Verification
REQ-026 Accept ADD, then ADDI, back-to-back -> E1: alu_func=RADD, reg_write=1, immediate=0, pc_en=1; next cycle: immediate=1; instr_ready stays 1.
REQ-027 BEQ with ZF=0, then BEQ with ZF=1, then JMP -> pc_rel_branch is 0, 1, 1 in successive cycles.
REQ-028 With MLT_CYCLES=3, issue MLTI -> alu_func=RMLT and immediate=1 for 3 cycles; reg_write=1 and pc_en=1 in cycle 3 only; instr_ready=0 in cycles 1-2.
REQ-029 STIN with in_valid raised in E4 -> read_in=1 in E1..E4; reg_write=1 and pc_en=1 in E4 only; LOUT with out_ready=1 in E1 -> write_out=1 and pc_en=1 in E1.
REQ-030 With MLT_CYCLES=3, pull n_reset low in E2 of MLT -> all outputs 0 immediately and no reg_write pulse; instr_ready=1 in the first cycle after release.
REQ-031 Build without CONTROL_UNIT_MLT_EN and issue MLT -> illegal_op=1 and pc_en=1 in E1, reg_write=0.
